// File: rtl/prt_dptx_scrm.sv
// DisplayPort TX scrambler with SR handling, one registered stage.
// Define PRT_DPTX_SCRM_SR_INS_EN to replace every 512th BS with SR.
module prt_dptx_scrm #(
  parameter int P_LANES = 4,
  parameter int P_SPL   = 2
) (
  input  logic                       RST_IN,
  input  logic                       CLK_IN,
  input  logic                       CTL_SCRM_EN_IN,
  input  logic                       CTL_LANES_IN,
  input  logic [P_LANES*P_SPL*8-1:0] LNK_DAT_IN,
  input  logic [P_LANES*P_SPL-1:0]   LNK_K_IN,
  input  logic                       LNK_VLD_IN,
  output logic [P_LANES*P_SPL*8-1:0] LNK_DAT_OUT,
  output logic [P_LANES*P_SPL-1:0]   LNK_K_OUT,
  output logic                       LNK_VLD_OUT
);
  localparam int NS = P_LANES * P_SPL;
  localparam logic [7:0] SYM_BS = 8'hBC;
  localparam logic [7:0] SYM_SR = 8'h1C;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic [15:0]     lfsr_q, lfsr_d;
  logic [NS*8-1:0] dat_d;
  logic [NS-1:0]   k_d;
`ifdef PRT_DPTX_SCRM_SR_INS_EN
  logic [8:0]      cnt_q, cnt_d;
`endif

  // Returns {keystream byte, LFSR after 8 steps}.
  function automatic logic [23:0] scr8(input logic [15:0] l);
    logic [7:0]  ks;
    logic [15:0] v;
    v = l;
    for (int i = 0; i < 8; i++) begin
      ks[i] = v[15];
      v = {v[14:0], 1'b0} ^ (v[15] ? 16'h0039 : 16'h0000);
    end
    return {ks, v};
  endfunction

  always_comb begin : comb
    logic [7:0]  d0;
    logic        k0;
    logic        sr;
    logic [23:0] ks;
    int          idx;
    lfsr_d = lfsr_q;
    dat_d  = LNK_DAT_IN;
    k_d    = LNK_K_IN;
    d0     = '0;
    k0     = 1'b0;
    sr     = 1'b0;
    ks     = '0;
    idx    = 0;
`ifdef PRT_DPTX_SCRM_SR_INS_EN
    cnt_d  = cnt_q;
`endif
    if (CTL_SCRM_EN_IN) begin
      // Lane 0 decides slot type; keystream chains slot to slot.
      for (int s = 0; s < P_SPL; s++) begin
        d0 = LNK_DAT_IN[s*8 +: 8];
        k0 = LNK_K_IN[s];
        sr = k0 && (d0 == SYM_SR);
        ks = scr8(lfsr_d);
`ifdef PRT_DPTX_SCRM_SR_INS_EN
        if (k0 && (d0 == SYM_BS)) begin
          if (cnt_d == 9'd0) sr = 1'b1;
          cnt_d = cnt_d + 9'd1;
        end
`endif
        for (int l = 0; l < P_LANES; l++) begin
          idx = l * P_SPL + s;
          if (sr) begin
            dat_d[idx*8 +: 8] = SYM_SR;
            k_d[idx]          = 1'b1;
          end else if (!LNK_K_IN[idx]) begin
            dat_d[idx*8 +: 8] = LNK_DAT_IN[idx*8 +: 8] ^ ks[23:16];
          end
        end
        lfsr_d = sr ? SEED : ks[15:0];
      end
      if (!LNK_VLD_IN) begin
        lfsr_d = lfsr_q;
`ifdef PRT_DPTX_SCRM_SR_INS_EN
        cnt_d  = cnt_q;
`endif
      end
    end else begin
      lfsr_d = SEED;
`ifdef PRT_DPTX_SCRM_SR_INS_EN
      cnt_d  = 9'd0;
`endif
    end
    if (!CTL_LANES_IN) begin
      for (int l = 2; l < P_LANES; l++) begin
        for (int s = 0; s < P_SPL; s++) begin
          idx = l * P_SPL + s;
          dat_d[idx*8 +: 8] = 8'h00;
          k_d[idx]          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      lfsr_q      <= SEED;
      LNK_DAT_OUT <= '0;
      LNK_K_OUT   <= '0;
      LNK_VLD_OUT <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      LNK_DAT_OUT <= dat_d;
      LNK_K_OUT   <= k_d;
      LNK_VLD_OUT <= LNK_VLD_IN;
    end
  end

`ifdef PRT_DPTX_SCRM_SR_INS_EN
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) cnt_q <= 9'd0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_prt_dptx_scrm.sv
// Self-checking bench for prt_dptx_scrm (P_LANES=4, P_SPL=2).
// Reference model tracks keystream position since the last seed.
module tb_prt_dptx_scrm;
  localparam bit SRINS =
`ifdef PRT_DPTX_SCRM_SR_INS_EN
    1'b1;
`else
    1'b0;
`endif
  localparam int KSB = 131072;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        lanes = 1'b1;
  logic [63:0] din = '0;
  logic [7:0]  kin = '0;
  logic        vin = 1'b0;
  logic [63:0] dout;
  logic [7:0]  kout;
  logic        vout;

  int nchk = 0;
  int nerr = 0;
  int m_pos = 0;
  int m_bs = 0;
  bit ksbits [KSB];

  prt_dptx_scrm #(.P_LANES(4), .P_SPL(2)) dut (
    .RST_IN(rst),
    .CLK_IN(clk),
    .CTL_SCRM_EN_IN(en),
    .CTL_LANES_IN(lanes),
    .LNK_DAT_IN(din),
    .LNK_K_IN(kin),
    .LNK_VLD_IN(vin),
    .LNK_DAT_OUT(dout),
    .LNK_K_OUT(kout),
    .LNK_VLD_OUT(vout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b0, input logic [7:0] b1);
    return {4{b1, b0}};
  endfunction

  function automatic logic [7:0] krep(input logic k0, input logic k1);
    return {4{k1, k0}};
  endfunction

  // Byte-level model: BS numbering by plain counting, keystream by position.
  task automatic mdl(input logic [63:0] d, input logic [7:0] k, input logic v,
                     output logic [63:0] od, output logic [7:0] ok);
    int p, b, idx;
    bit sr;
    logic [7:0] kb;
    od = d;
    ok = k;
    p = m_pos;
    b = m_bs;
    if (en) begin
      for (int s = 0; s < 2; s++) begin
        sr = k[s] && (d[s*8 +: 8] == 8'h1C);
        if (SRINS && k[s] && (d[s*8 +: 8] == 8'hBC)) begin
          if ((b % 512) == 0) sr = 1'b1;
          b++;
        end
        for (int i = 0; i < 8; i++) kb[i] = ksbits[(p*8 + i) % KSB];
        for (int l = 0; l < 4; l++) begin
          idx = l * 2 + s;
          if (sr) begin
            od[idx*8 +: 8] = 8'h1C;
            ok[idx] = 1'b1;
          end else if (!k[idx]) begin
            od[idx*8 +: 8] = d[idx*8 +: 8] ^ kb;
          end
        end
        p = sr ? 0 : p + 1;
      end
      if (v) begin
        m_pos = p;
        m_bs = b;
      end
    end else begin
      m_pos = 0;
      m_bs = 0;
    end
    if (!lanes) begin
      od[63:32] = '0;
      ok[7:4] = '0;
    end
  endtask

  task automatic cyc(input logic [63:0] d, input logic [7:0] k, input logic v);
    logic [63:0] ed;
    logic [7:0] ek;
    din = d;
    kin = k;
    vin = v;
    mdl(d, k, v, ed, ek);
    @(posedge clk);
    #1;
    chk("dat", dout, ed);
    chk("k", {56'd0, kout}, {56'd0, ek});
    chk("vld", {63'd0, vout}, {63'd0, v});
  endtask

  task automatic rnd(output logic [63:0] d, output logic [7:0] k);
    d = {$urandom, $urandom};
    k = 8'($urandom) & 8'($urandom);
    for (int s = 0; s < 2; s++)
      if (k[s] && (d[s*8 +: 8] == 8'hBC || d[s*8 +: 8] == 8'h1C))
        d[s*8 +: 8] = 8'hFB;
    if ($urandom_range(0, 7) == 0) begin
      for (int l = 0; l < 4; l++) d[l*16 +: 8] = 8'hBC;
      k = k | krep(1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] l;
    logic [63:0] d;
    logic [7:0] k;
    int srn, bsn;
    l = 16'hFFFF;
    for (int i = 0; i < KSB; i++) begin
      ksbits[i] = l[15];
      l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end

    @(posedge clk);
    #1;
    chk("rst_dat", dout, 64'd0);
    chk("rst_k", {56'd0, kout}, 64'd0);
    chk("rst_vld", {63'd0, vout}, 64'd0);
    rst = 1'b0;
    en = 1'b1;
    lanes = 1'b1;

    cyc(rep(SRINS ? 8'hBC : 8'h1C, 8'h00), krep(1'b1, 1'b0), 1'b1);
    chk("basic_sr", {56'd0, dout[55:48]}, 64'h1C);
    chk("basic_srk", {63'd0, kout[6]}, 64'd1);
    chk("basic_b0", {56'd0, dout[15:8]}, 64'hFF);
    cyc(rep(8'h00, 8'h00), 8'h00, 1'b1);
    chk("basic_b1", {56'd0, dout[7:0]}, 64'h17);
    chk("basic_b2", {56'd0, dout[15:8]}, 64'hC0);
    cyc(rep(8'h00, 8'h00), 8'h00, 1'b1);
    chk("basic_b3", {56'd0, dout[7:0]}, 64'h14);

    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rnd(d, k);
      cyc(d, k, 1'b1);
      chk("pass", dout, d);
    end

    en = 1'b1;
    srn = 0;
    for (int n = 1; n <= 1025; n++) begin
      cyc(rep(8'hBC, 8'h00), krep(1'b1, 1'b0), 1'b1);
      if (kout[0] && dout[7:0] == 8'h1C) begin
        srn++;
        chk("sr_pos", 64'((n - 1) % 512), 64'd0);
        chk("sr_next", {56'd0, dout[15:8]}, 64'hFF);
      end
    end
    chk("sr_count", 64'(srn), SRINS ? 64'd3 : 64'd0);

    lanes = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(rep(8'hAA, 8'hAA), 8'h00, 1'b1);
      chk("lane_hi", dout[63:32], 64'd0);
      chk("lane_eq", {48'd0, dout[31:16]}, {48'd0, dout[15:0]});
    end
    lanes = 1'b1;

    bsn = 0;
    for (int i = 0; i < 25; i++) begin
      rnd(d, k);
      cyc(d, k, !(i >= 8 && i < 18));
    end

    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) lanes = 1'($urandom);
      if (i % 67 == 66) en = ~en;
      rnd(d, k);
      cyc(d, k, 1'($urandom_range(0, 5) != 0));
    end
    en = 1'b1;
    lanes = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(rep(8'h5A, 8'hA5), 8'h00, 1'b1);
    end

    rst = 1'b1;
    #1;
    chk("arst_dat", dout, 64'd0);
    chk("arst_k", {56'd0, kout}, 64'd0);
    chk("arst_vld", {63'd0, vout}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pos = 0;
    m_bs = 0;
    cyc(rep(SRINS ? 8'hBC : 8'h1C, 8'h00), krep(1'b1, 1'b0), 1'b1);
    chk("arst_sr", {56'd0, dout[7:0]}, 64'h1C);
    chk("arst_ff", {56'd0, dout[15:8]}, 64'hFF);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/prt_dptx_scrm.md
# prt_dptx_scrm

DisplayPort TX scrambler and scrambler-reset (SR) inserter. It sits on the link symbol path directly downstream of the TX control register block, and takes its CTL_SCRM_EN and CTL_LANES outputs as static-per-cycle controls. Each enabled lane is scrambled with the DP LFSR (G(X)=X^16+X^5+X^4+X^3+1). Every 512th BS is replaced by SR, and the LFSR is re-seeded on SR. The result goes to the PHY lane mapper with one cycle of latency.

## Interface
Parameters:
- P_LANES, 4, number of physical lanes; 4 is the only supported value.
- P_SPL, 2, symbols per lane per clock; 2 or 4.

Ports:
- RST_IN  in  1  reset, asynchronous, active-high.
- CLK_IN  in  1  link clock.
- CTL_SCRM_EN_IN  in  1  scrambler enable.
- CTL_LANES_IN  in  1  active lanes: 0 selects lanes 0–1, 1 selects lanes 0–3.
- LNK_DAT_IN  in  P_LANES*P_SPL*8  symbol data; lane L, symbol S occupies bits [(L*P_SPL+S)*8 +: 8]; S=0 is earliest.
- LNK_K_IN  in  P_LANES*P_SPL  K-flag per symbol, same ordering.
- LNK_VLD_IN  in  1  input valid.
- LNK_DAT_OUT  out  P_LANES*P_SPL*8  scrambled data.
- LNK_K_OUT  out  P_LANES*P_SPL  K-flags.
- LNK_VLD_OUT  out  1  output valid.

## Operation
- **Symbol codes:** BS = K28.5 (K=1, 0xBC); SR = K28.0 (K=1, 0x1C).
- **Shared state, lane 0 as reference:** one shared 16-bit LFSR and one 9-bit BS counter are advanced from lane 0 symbols only. Upstream guarantees BS/SR land in the same slot on all lanes, so all active lanes apply the same keystream per slot.
- **SR replacement:** when CTL_SCRM_EN_IN=1, symbols are processed in slot order S=0..P_SPL-1. For a BS in lane 0:
  - If the counter is 0, that slot becomes SR on all active lanes.
  - The counter then increments, wrapping modulo 512.
  - Consequence: the first BS after enable becomes SR, then every 512th BS after it.
- **LFSR handling per slot, in order:**
  - SR slot: output SR unscrambled; LFSR ← 0xFFFF; no advance.
  - K symbol other than SR: output unscrambled; LFSR advances 8 steps.
  - D symbol: out bit i (i=0 first) = in bit i XOR lfsr[15] before step i; LFSR advances 8 steps.
  - One step: lfsr ← {lfsr[14:0],1'b0} XOR (lfsr[15] ? 16'h0039 : 16'h0000).
  - Multiple BS/SR within one clock are handled sequentially; the next-slot keystream is computed combinationally from the updated state.
- **Disabled:** when CTL_SCRM_EN_IN=0, data and K pass through unchanged. The LFSR is held at 0xFFFF and the BS counter at 0.
- **Inactive lanes:** when CTL_LANES_IN=0, lanes 2–3 output data 0 and K 0, regardless of their inputs.
- **Invalid input:** when LNK_VLD_IN=0, the LFSR and counter hold and the output is registered with LNK_VLD_OUT=0.
- **Control changes:** a change on CTL_SCRM_EN_IN or CTL_LANES_IN applies to the data sampled in that same cycle.

## Timing
- Latency: exactly 1 clock from input to output; all outputs are registered.
- Reset values: LNK_DAT_OUT=0, LNK_K_OUT=0, LNK_VLD_OUT=0; internal LFSR=0xFFFF, counter=0.
- Enable 1→0: the same-cycle data passes unscrambled, and the state is re-seeded at that clock edge.
- Enable 0→1: the first BS seen becomes SR; any D symbols before that BS use seed 0xFFFF.
- Reset mid-stream: outputs clear immediately and asynchronously; the first post-reset BS with enable=1 becomes SR.
- Counter wrap: 511→0 with no gap; BS number 513 after the first SR is again replaced.

## Configuration
- Macro: PRT_DPTX_SCRM_SR_INS_EN.
- Defined: SR replacement of every 512th BS is active, as described above.
- Not defined:
  - BS passes through unchanged and the BS counter is removed.
  - The LFSR re-seeds on any SR arriving from upstream in lane 0; that SR is output unchanged.
  - All other behaviour is identical.

## Test plan
- **Basic scrambling:** enable=1, BS then D 0x00 on all slots → one cycle later: SR in slot 0 on lanes 0–3, then D bytes 0xFF, 0x17, 0xC0, 0x14.
- **Pass-through:** enable=0, random D/K stream → output equals input delayed one clock, with SR never inserted.
- **SR period:** enable=1, 1025 BS with D 0x00 fill → SR replaces BS numbers 1, 513 and 1025 only; the byte following each SR is 0xFF.
- **Lane count:** CTL_LANES_IN=0 with 0xAA driven on all lanes → lanes 2–3 show data 0x00 and K 0; lanes 0–1 are scrambled and identical to each other.
- **Valid gaps:** enable=1, LNK_VLD_IN deasserted for 10 cycles mid-stream → output keystream continues without skip or repeat, and LNK_VLD_OUT mirrors the input one cycle late.
- **Async reset:** RST_IN pulsed mid-stream → outputs 0 immediately; after release, the first BS becomes SR and the following D 0x00 byte scrambles to 0xFF.
